// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master core.
// - Strobe indices for the write (WRn) and read (DRn) decode vectors.
// - Bit positions of the CONFIG, CMD and STATE fields.
// - FSM state type and the bit-order helpers used by the shifter.
package spi_pkg;

  // Write strobe indices
  localparam int WR_CONFIG = 0;
  localparam int WR_TX     = 1;
  localparam int WR_RX     = 2;
  localparam int WR_CMD    = 3;

  // Read strobe indices
  localparam int RD_STATE  = 0;
  localparam int RD_RX     = 1;
  localparam int RD_CONFIG = 2;
  localparam int RD_RSVD   = 3;

  // CONFIG fields; DIV occupies the low DIV_W bits
  localparam int CFG_CPOL      = 3;
  localparam int CFG_CPHA      = 4;
  localparam int CFG_LSB_FIRST = 5;

  // CMD fields
  localparam int CMD_START      = 0;
  localparam int CMD_CS_HOLD    = 1;
  localparam int CMD_CS_RELEASE = 2;

  // STATE fields
  localparam int ST_BUSY     = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_TX_FULL  = 3;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE_ST} state_t;

  // Bit that goes onto MOSI next.
  function automatic logic out_bit(input logic [7:0] d, input logic lsb_first);
    return lsb_first ? d[0] : d[7];
  endfunction

  // Shifter contents after the current bit has been driven.
  function automatic logic [7:0] tx_shift(input logic [7:0] d, input logic lsb_first);
    return lsb_first ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
  endfunction

  // Receive shifter after taking one MISO sample.
  function automatic logic [7:0] rx_shift(input logic [7:0] d, input logic lsb_first,
                                          input logic in_bit);
    return lsb_first ? {in_bit, d[7:1]} : {d[6:0], in_bit};
  endfunction

endpackage

// File: rtl/spi_master_core_if.sv
// Register-access bus between the APB address decoder and the SPI core.
// - WR0..WR3 : one-cycle write strobes (CONFIG, TX, RX flag clear, CMD).
// - DR0..DR3 : one-cycle read strobes (STATE, RX, CONFIG, reserved).
// - PWDATA   : write data, valid in the strobe cycle.
// - PRDATA   : registered read data returned by the core.
// The decoder uses the master modport, the core the slave modport.
interface spi_master_core_if;
  logic       WR0, WR1, WR2, WR3;
  logic       DR0, DR1, DR2, DR3;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;

  modport master (output WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3, PWDATA,
                  input  PRDATA);
  modport slave  (input  WR0, WR1, WR2, WR3, DR0, DR1, DR2, DR3, PWDATA,
                  output PRDATA);
endinterface

// File: rtl/spi_clkgen.sv
// Half-period tick generator for the SPI clock.
// - PCLK, PRESET : system clock, synchronous active-high reset.
// - en           : counts while high, counter held at 0 while low.
// - div          : exponent; tick fires every 2^div cycles.
// - tick         : one-cycle pulse marking each SCLK half-period boundary.
module spi_clkgen #(
  parameter int DIV_W = 3
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam int CNT_W = (1 << DIV_W) - 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  // limit = 2^div - 1, built as a mask of div low ones
  assign limit = ~({CNT_W{1'b1}} << div);
  assign tick  = en && (cnt == limit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge PCLK) begin
    if (PRESET || !en || tick) cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/spi_master_core.sv
// SPI master engine (modes 0-3, one byte per transfer) behind the APB decoder.
// - PCLK, PRESET   : system clock, synchronous active-high reset.
// - bus            : register strobes, write data and registered read data.
// - SCLK/MOSI/CS_n : SPI outputs; MISO is already synchronised.
// - DONE           : one-cycle pulse when a transfer completes.
module spi_master_core #(
  parameter int   DIV_W   = 3,
  parameter logic CS_IDLE = 1'b1
) (
  input  logic               PCLK,
  input  logic               PRESET,
  spi_master_core_if.slave   bus,
  output logic               SCLK,
  output logic               MOSI,
  input  logic               MISO,
  output logic               CS_n,
  output logic               DONE
);
  import spi_pkg::*;

  state_t     state;
  logic [7:0] cfg, tx, rx, tx_sh, rx_sh, status;
  logic       rx_valid, overrun, tx_full, cs_hold;
  logic [3:0] tcnt;
  logic [3:0] wr, dr;
  logic       busy, clk_en, tick, cpol, cpha, lsb, sample;

  assign wr     = {bus.WR3, bus.WR2, bus.WR1, bus.WR0};
  assign dr     = {bus.DR3, bus.DR2, bus.DR1, bus.DR0};
  assign busy   = (state != IDLE);
  assign clk_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);
  assign cpol   = cfg[CFG_CPOL];
  assign cpha   = cfg[CFG_CPHA];
  assign lsb    = cfg[CFG_LSB_FIRST];
  // Even tcnt = odd tick = leading edge; CPHA=0 samples there, CPHA=1 on trailing.
  assign sample = ~tcnt[0] ^ cpha;

  spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .en     (clk_en),
    .div    (cfg[DIV_W-1:0]),
    .tick   (tick)
  );

  // NOTE: a default assignment first keeps this combinational block latch-free.
  always_comb begin
    status              = '0;
    status[ST_BUSY]     = busy;
    status[ST_RX_VALID] = rx_valid;
    status[ST_OVERRUN]  = overrun;
    status[ST_TX_FULL]  = tx_full;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      cfg        <= '0;
      tx         <= '0;
      rx         <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      tx_full    <= 1'b0;
      cs_hold    <= 1'b0;
      tcnt       <= '0;
      bus.PRDATA <= '0;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      CS_n       <= CS_IDLE;
      DONE       <= 1'b0;
    end else begin
      DONE <= 1'b0;

      if (wr[WR_CONFIG] && !busy) cfg <= {2'b00, bus.PWDATA[5:0]};
      // Clears come before the FSM so a same-cycle set from completion wins.
      if (wr[WR_RX]) overrun  <= 1'b0;
      if (dr[RD_RX]) rx_valid <= 1'b0;

      if      (dr[RD_STATE])  bus.PRDATA <= status;
      else if (dr[RD_RX])     bus.PRDATA <= rx;
      else if (dr[RD_CONFIG]) bus.PRDATA <= cfg;
      else if (dr[RD_RSVD])   bus.PRDATA <= '0;

      case (state)
        IDLE: begin
          SCLK <= cpol;
          tcnt <= '0;
          if (wr[WR_CMD] && bus.PWDATA[CMD_CS_RELEASE]) CS_n <= CS_IDLE;
          if (wr[WR_CMD] && bus.PWDATA[CMD_START]) begin
            state   <= SETUP;
            CS_n    <= 1'b0;
            cs_hold <= bus.PWDATA[CMD_CS_HOLD];
            tx_full <= 1'b0;
            if (!cpha) begin
              // CPHA=0: first bit must be valid before the first leading edge.
              MOSI  <= out_bit(tx, lsb);
              tx_sh <= tx_shift(tx, lsb);
            end else begin
              tx_sh <= tx;
            end
          end
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          SCLK <= ~SCLK;
          tcnt <= tcnt + 4'd1;
          if (sample) begin
            rx_sh <= rx_shift(rx_sh, lsb, MISO);
          end else if (tcnt != 4'd15) begin
            MOSI  <= out_bit(tx_sh, lsb);
            tx_sh <= tx_shift(tx_sh, lsb);
          end
          if (tcnt == 4'd15) begin
            state <= HOLD;
            SCLK  <= cpol;
          end
        end
        HOLD: if (tick) begin
          state    <= DONE_ST;
          rx       <= rx_sh;
          rx_valid <= 1'b1;
          if (rx_valid) overrun <= 1'b1;
          CS_n     <= cs_hold ? 1'b0 : CS_IDLE;
          DONE     <= 1'b1;
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase

      // TX is independent of the shifter, so a write here always lands.
      if (wr[WR_TX]) begin
        tx      <= bus.PWDATA;
        tx_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Directed self-checking bench for spi_master_core.
module tb_spi_master_core;

  logic PCLK = 1'b0;
  logic PRESET;
  logic SCLK, MOSI, CS_n, DONE;
  logic MISO;
  logic loop_en, miso_tie;

  spi_master_core_if bus ();

  spi_master_core #(.DIV_W(3), .CS_IDLE(1'b1)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .CS_n   (CS_n),
    .DONE   (DONE)
  );

  always #5 PCLK = ~PCLK;

  assign MISO = loop_en ? MOSI : miso_tie;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          rise_cnt = 0;
  int          cs_high  = 0;
  logic        cs_watch = 1'b0;
  logic [7:0]  mosi_rec = '0;
  int unsigned rise_t [256];

  always @(posedge PCLK) begin
    if (DONE === 1'b1) done_cnt++;
    if (cs_watch && CS_n !== 1'b0) cs_high++;
  end

  always @(posedge SCLK) begin
    if (rise_cnt < 256) rise_t[rise_cnt] = 32'($time);
    mosi_rec = {mosi_rec[6:0], MOSI};
    rise_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    bus.PWDATA = d;
    case (idx)
      0:       bus.WR0 = 1'b1;
      1:       bus.WR1 = 1'b1;
      2:       bus.WR2 = 1'b1;
      default: bus.WR3 = 1'b1;
    endcase
    step(1);
    bus.WR0 = 1'b0; bus.WR1 = 1'b0; bus.WR2 = 1'b0; bus.WR3 = 1'b0;
    bus.PWDATA = '0;
  endtask

  task automatic rd(input int idx, output logic [7:0] d);
    case (idx)
      0:       bus.DR0 = 1'b1;
      1:       bus.DR1 = 1'b1;
      2:       bus.DR2 = 1'b1;
      default: bus.DR3 = 1'b1;
    endcase
    step(1);
    bus.DR0 = 1'b0; bus.DR1 = 1'b0; bus.DR2 = 1'b0; bus.DR3 = 1'b0;
    d = bus.PRDATA;
  endtask

  // Cycles from the START edge until DONE is seen high; stops at bound.
  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (DONE !== 1'b1 && cycles < bound) begin
      step(1);
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int cyc, base_done, base_rise;

    PRESET   = 1'b1;
    loop_en  = 1'b0;
    miso_tie = 1'b0;
    bus.WR0 = 1'b0; bus.WR1 = 1'b0; bus.WR2 = 1'b0; bus.WR3 = 1'b0;
    bus.DR0 = 1'b0; bus.DR1 = 1'b0; bus.DR2 = 1'b0; bus.DR3 = 1'b0;
    bus.PWDATA = '0;

    // Reset state
    step(3);
    check("rst_cs_n", CS_n, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_done", DONE, 0);
    PRESET = 1'b0;
    rd(0, d); check("rst_state", d, 8'h00);
    rd(1, d); check("rst_rx", d, 8'h00);
    rd(2, d); check("rst_config", d, 8'h00);
    check("rst_no_done", done_cnt, 0);

    // Mode 0, DIV=0, loopback of 0xA5
    loop_en = 1'b1;
    wr(0, 8'h00);
    wr(1, 8'hA5);
    base_done = done_cnt;
    base_rise = rise_cnt;
    wr(3, 8'h01);
    wait_done(100, cyc);
    check("m0_latency", cyc, 18);
    step(2);
    check("m0_done_once", done_cnt - base_done, 1);
    check("m0_sclk_rises", rise_cnt - base_rise, 8);
    check("m0_sclk_spacing", rise_t[base_rise+7] - rise_t[base_rise], 140);
    check("m0_mosi_seq", mosi_rec, 8'hA5);
    check("m0_cs_n_idle", CS_n, 1);
    rd(1, d); check("m0_rx", d, 8'hA5);
    rd(0, d); check("m0_state", d, 8'h00);

    // CONFIG readback, reserved bits, reserved read
    wr(0, 8'hFF);
    rd(2, d); check("cfg_reserved_bits", d, 8'h3F);
    wr(0, 8'h3A);
    rd(2, d); check("cfg_readback", d, 8'h3A);
    rd(3, d); check("dr3_zero", d, 8'h00);
    check("m3_sclk_idle_high", SCLK, 1);

    // Mode 3, LSB first, DIV=2, MISO tied high
    loop_en  = 1'b0;
    miso_tie = 1'b1;
    wr(1, 8'h01);
    base_done = done_cnt;
    base_rise = rise_cnt;
    wr(3, 8'h01);
    wait_done(300, cyc);
    check("m3_latency", cyc, 72);
    step(2);
    check("m3_done_once", done_cnt - base_done, 1);
    check("m3_sclk_rises", rise_cnt - base_rise, 8);
    check("m3_sclk_spacing", rise_t[base_rise+7] - rise_t[base_rise], 560);
    check("m3_mosi_seq", mosi_rec, 8'h80);
    check("m3_sclk_back_high", SCLK, 1);
    rd(0, d); check("m3_state", d, 8'h02);
    rd(1, d); check("m3_rx", d, 8'hFF);

    // Two transfers without reading RX -> overrun
    wr(0, 8'h00);
    loop_en = 1'b1;
    wr(1, 8'h3C);
    wr(3, 8'h01);
    wait_done(100, cyc);
    check("ovr_first_latency", cyc, 18);
    step(1);
    wr(1, 8'hC3);
    wr(3, 8'h01);
    wait_done(100, cyc);
    step(1);
    rd(0, d); check("ovr_state", d, 8'h06);
    wr(2, 8'hFF);
    rd(0, d); check("ovr_cleared", d, 8'h02);
    rd(1, d); check("ovr_rx_second", d, 8'hC3);

    // CS hold across back-to-back bytes, busy CONFIG/START ignored, release
    base_done = done_cnt;
    wr(1, 8'h55);
    wr(3, 8'h03);
    cs_watch = 1'b1;
    step(3);
    wr(0, 8'h07);
    wr(3, 8'h01);
    wait_done(100, cyc);
    check("busy_start_ignored", cyc, 13);
    check("hold_cs_low", CS_n, 0);
    wr(1, 8'hAA);
    wr(3, 8'h03);
    wait_done(100, cyc);
    check("b2b_latency", cyc, 18);
    cs_watch = 1'b0;
    check("hold_cs_continuous", cs_high, 0);
    check("hold_cs_low2", CS_n, 0);
    step(2);
    check("hold_done_count", done_cnt - base_done, 2);
    rd(2, d); check("busy_config_ignored", d, 8'h00);
    wr(3, 8'h04);
    check("release_cs", CS_n, 1);

    // Reset at tick 7 of SHIFT
    wr(1, 8'h0F);
    wr(3, 8'h01);
    base_done = done_cnt;
    step(7);
    check("pre_rst_cs_low", CS_n, 0);
    PRESET = 1'b1;
    step(1);
    check("rst_mid_cs_n", CS_n, 1);
    check("rst_mid_sclk", SCLK, 0);
    check("rst_mid_done", DONE, 0);
    PRESET = 1'b0;
    rd(0, d); check("rst_mid_state", d, 8'h00);
    step(40);
    check("rst_mid_no_done", done_cnt - base_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- SPI master engine directly downstream of the APB address-decode stage.
- Consumes the one-cycle WR0..WR3 / DR0..DR3 strobes and the gated 8-bit PWDATA.
- Holds the CONFIG, TX, RX, CMD and STATE registers, returns read data on PRDATA, and drives an SPI Mode 0–3 bus (SCLK/MOSI/MISO/CS_n), one byte per transfer.

Parameters:
- DIV_W, 3, width of the clock-divide exponent field in CONFIG.
- CS_IDLE, 1'b1, level of CS_n when deasserted.

Ports:
- PCLK  in  1  system clock; all logic on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- WR0  in  1  write strobe, CONFIG.
- WR1  in  1  write strobe, TX.
- WR2  in  1  write strobe, RX (flag clear).
- WR3  in  1  write strobe, CMD.
- DR0  in  1  read strobe, STATE.
- DR1  in  1  read strobe, RX.
- DR2  in  1  read strobe, CONFIG readback.
- DR3  in  1  read strobe, reserved; reads 0x00.
- PWDATA  in  8  write data, valid in the strobe cycle.
- PRDATA  out  8  registered read data.
- SCLK  out  1  SPI clock.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in (already synchronised externally).
- CS_n  out  1  chip select, active low.
- DONE  out  1  one-cycle pulse at transfer end.

Behaviour:
- Reset: CONFIG=0x00, TX=0x00, RX=0x00, all flags 0, PRDATA=0x00, SCLK=0, MOSI=0, CS_n=CS_IDLE, DONE=0, FSM=IDLE.
  - Reset mid-transfer aborts at the same edge; no DONE.
- CONFIG layout:
  - [2:0] DIV: half-period = 2^DIV PCLK cycles.
  - [3] CPOL.
  - [4] CPHA.
  - [5] LSB_FIRST.
  - [7:6] reserved; write ignored, read 0.
- WR0 while busy is ignored. SCLK follows CPOL in IDLE.
- WR1: TX<=PWDATA; tx_full<=1. Overwrite is allowed, including while busy, because the shifter owns its own copy.
- WR2: clears overrun. Data is ignored.
- WR3 CMD bits:
  - [0] START: accepted only in IDLE. Copies TX into the shifter and clears tx_full. START while busy is ignored.
  - [1] CS_HOLD: latched per transfer; keeps CS_n low after DONE.
  - [2] CS_RELEASE: in IDLE only, drives CS_n<=CS_IDLE.
- STATE readback: [0] busy, [1] rx_valid, [2] overrun, [3] tx_full, [7:4]=0.
- Read path: on DRn, PRDATA is loaded at the next edge (1-cycle latency) and held until the next DR strobe.
  - DR1 clears rx_valid.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE_ST.
  - IDLE --START--> SETUP: CS_n<=0. If CPHA=0, MOSI is driven with the first bit.
  - SETUP: lasts one half-period, then --> SHIFT.
  - SHIFT: 16 half-period ticks. SCLK toggles on each tick.
    - CPHA=0: sample MISO on odd ticks (leading edge), shift MOSI on even ticks.
    - CPHA=1: shift on odd ticks, sample on even ticks.
    - Bit counter runs 0..7, MSB first unless LSB_FIRST.
  - SHIFT --> HOLD: after tick 16, SCLK=CPOL. HOLD lasts one half-period.
  - HOLD --> DONE_ST: RX<=shift result; rx_valid<=1. If rx_valid was already 1, overrun<=1 and RX is overwritten. CS_n<=CS_IDLE unless CS_HOLD. DONE=1 for one cycle.
  - DONE_ST --> IDLE.
- Divider counter reloads on every tick and is held at 0 in IDLE. DIV=0 gives SCLK = PCLK/2.
- Simultaneous DR1 and completion in the same cycle: PRDATA gets the old RX, and rx_valid stays 1 (new data wins).
- Simultaneous WR2 and an overrun set in the same cycle: set wins.
- Back-to-back: START is accepted in the cycle after DONE_ST. With CS_HOLD, CS_n stays low continuously.

Decomposition:
- Package spi_pkg:
  - register index constants CONFIG/TX/RX/CMD/STATE;
  - bit positions for the CONFIG, CMD and STATE fields;
  - state enum {IDLE, SETUP, SHIFT, HOLD, DONE_ST}.
- One sub-module, spi_clkgen: inputs PCLK, PRESET, en, div. Output tick, a one-cycle pulse every 2^div cycles while en=1.

Test Plan:
- Reset then DR0, DR1, DR2 -> PRDATA=0x00 each; CS_n=1, SCLK=0, DONE never pulses.
- CONFIG=0x00 (mode 0, DIV=0), WR1 0xA5, WR3 0x01, MISO loopback from MOSI:
  - 8 SCLK rising edges, 2 PCLK apart;
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - DONE pulses once;
  - DR1 -> PRDATA=0xA5; then DR0 -> 0x00.
- CONFIG=0x3A (CPOL=1, CPHA=1, LSB_FIRST, DIV=2), TX=0x01, MISO tied 1:
  - SCLK idles high with a half-period of 4 cycles;
  - MOSI's first bit is 1;
  - RX=0xFF; STATE=0x02.
- Two transfers without reading RX:
  - STATE reads 0x06 (rx_valid, overrun);
  - WR2 -> STATE=0x02;
  - DR1 -> PRDATA = the second byte.
- CMD 0x03 then 0x01 -> CS_n stays low across both bytes; CMD 0x04 -> CS_n=1. START written while busy -> ignored, only one DONE.
- PRESET asserted at tick 7 of SHIFT -> next edge: CS_n=1, SCLK=0, STATE=0x00, no DONE.
